// File: rtl/expu_corr_arbiter.sv
// ============================================================================
// Module      : expu_corr_arbiter
// Description : Round-robin arbiter and tag pipeline sharing one exponential
//               mantissa correction datapath among NUM_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expu_corr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_FRACTION = 7,
  parameter int DP_LATENCY     = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*INPUT_FRACTION-1:0]   req_mant_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic [INPUT_FRACTION-1:0]           rsp_mant_o,
  output logic                                dp_enable_o,
  output logic                                dp_clear_o,
  output logic [INPUT_FRACTION-1:0]           dp_mant_o,
  input  logic [INPUT_FRACTION-1:0]           dp_mant_i
);

  localparam int                c_ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                c_W         = INPUT_FRACTION;
  localparam int                c_TAIL      = DP_LATENCY - 1;
  localparam logic [c_ID_W-1:0] c_LAST_INIT = c_ID_W'(NUM_REQ - 1);

  logic [DP_LATENCY-1:0]             r_tag_valid;
  logic [DP_LATENCY-1:0][c_ID_W-1:0] r_tag_id;
  logic [c_ID_W-1:0]                 r_last;

  logic              w_tail_valid;
  logic [c_ID_W-1:0] w_tail_id;
  logic              w_tail_ready;
  logic              w_stall;
  logic              w_advance;
  logic              w_grant_any;
  logic [c_ID_W-1:0] w_grant_id;

  // Requester at priority position k (1..NUM_REQ) after base, modulo NUM_REQ.
  function automatic logic [c_ID_W-1:0] rr_idx(input logic [c_ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return c_ID_W'(s);
  endfunction

  assign w_tail_valid = r_tag_valid[c_TAIL];
  assign w_tail_id    = r_tag_id[c_TAIL];

  always_comb begin
    w_tail_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_tail_id == c_ID_W'(i)) w_tail_ready = rsp_ready_i[i];
    end
  end

  assign w_stall     = w_tail_valid & ~w_tail_ready;
  assign w_advance   = ~w_stall;
  assign dp_enable_o = w_advance;
  assign dp_clear_o  = clear_i;
  assign rsp_mant_o  = dp_mant_i;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    if (w_advance && !clear_i) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (req_valid_i[rr_idx(r_last, k)]) begin
          w_grant_any = 1'b1;
          w_grant_id  = rr_idx(r_last, k);
        end
      end
    end
  end

  always_comb begin
    dp_mant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_any && (w_grant_id == c_ID_W'(i))) dp_mant_o = req_mant_i[i*c_W +: c_W];
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign req_ready_o[i] = w_grant_any  & (w_grant_id == c_ID_W'(i));
    assign rsp_valid_o[i] = w_tail_valid & (w_tail_id  == c_ID_W'(i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tag_valid <= '0;
      r_tag_id    <= '0;
      r_last      <= c_LAST_INIT;
    end else if (clear_i) begin
      r_tag_valid <= '0;
      r_last      <= c_LAST_INIT;
    end else if (w_advance) begin
      r_tag_valid[0] <= w_grant_any;
      r_tag_id[0]    <= w_grant_id;
      for (int k = 1; k < DP_LATENCY; k++) begin
        r_tag_valid[k] <= r_tag_valid[k-1];
        r_tag_id[k]    <= r_tag_id[k-1];
      end
      if (w_grant_any) r_last <= w_grant_id;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_expu_corr_arbiter.sv
// ============================================================================
// Module      : tb_expu_corr_arbiter
// Description : Scoreboard bench for expu_corr_arbiter with a golden
//               one-stage correction datapath model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expu_corr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 7;
  localparam int DP_LAT  = 1;

  typedef struct {
    int           id;
    logic [W-1:0] mant;
  } sb_entry_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*W-1:0] req_mant = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready = '0;
  logic [W-1:0]         rsp_mant;
  logic                 dp_enable;
  logic                 dp_clear;
  logic [W-1:0]         dp_mant_out;
  logic [W-1:0]         dp_q;

  logic [W-1:0]         m [NUM_REQ];
  logic [NUM_REQ-1:0]   granted = '0;
  logic [W-1:0]         held_mant;
  sb_entry_t            sb_q [$];
  int                   n_assert = 0;
  int                   n_fail   = 0;

  always #5 clk = ~clk;

  expu_corr_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .INPUT_FRACTION (W),
    .DP_LATENCY     (DP_LAT)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .req_valid_i (req_valid),
    .req_mant_i  (req_mant),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_mant_o  (rsp_mant),
    .dp_enable_o (dp_enable),
    .dp_clear_o  (dp_clear),
    .dp_mant_o   (dp_mant_out),
    .dp_mant_i   (dp_q)
  );

  function automatic logic [W-1:0] corr(input logic [W-1:0] x);
    logic [8:0] t;
    t = {2'b00, x} * 9'd3 + 9'd5;
    return t[W-1:0];
  endfunction

  // Golden single-stage correction datapath.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         dp_q <= '0;
    else if (dp_clear)  dp_q <= '0;
    else if (dp_enable) dp_q <= corr(dp_mant_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack_mants();
    for (int i = 0; i < NUM_REQ; i++) req_mant[i*W +: W] = m[i];
  endtask

  // Advance to just after the next rising edge; granted requesters get fresh data.
  task automatic pedge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted[i]) m[i] = W'($urandom_range(0, (1 << W) - 1));
    end
    pack_mants();
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Scoreboard: push on grant, pop on response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      granted = '0;
    end else begin
      if (rsp_valid != '0 && sb_q.size() == 0)
        check("rsp_spurious", 32'(rsp_valid), 32'h0);
      if (|(rsp_valid & rsp_ready) && sb_q.size() != 0) begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
        check("rsp_mant", 32'(rsp_mant), 32'(e.mant));
      end
      granted = req_ready;
      if (clear) begin
        sb_q.delete();
      end else if (req_ready != '0) begin
        if (!$onehot(req_ready)) check("ready_onehot", 32'(req_ready), 32'h0);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) sb_q.push_back('{id: i, mant: corr(m[i])});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) m[i] = W'(8'h11 * i + 3);
    pack_mants();

    // Reset state
    nedge();
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_dp_enable", 32'(dp_enable), 32'h1);
    check("rst_dp_clear", 32'(dp_clear), 32'h0);
    pedge();
    rst_n = 1'b1;

    // 1: round-robin order with all requesters valid
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int c = 0; c < 8; c++) begin
      nedge();
      check("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
      if (c > 0) check("rr_rsp", 32'(rsp_valid), 32'(1) << ((c - 1) % 4));
      pedge();
    end
    req_valid = '0;
    nedge();
    check("rr_rsp_last", 32'(rsp_valid), 32'h8);
    pedge();

    // 2: single requester back-to-back
    req_valid = 4'b0100;
    m[2] = 7'h00; pack_mants();
    nedge(); check("tp_grant0", 32'(req_ready), 32'h4);
    pedge(); m[2] = 7'h40; pack_mants();
    nedge(); check("tp_grant1", 32'(req_ready), 32'h4);
    check("tp_rsp0", 32'(rsp_valid), 32'h4);
    pedge(); m[2] = 7'h7F; pack_mants();
    nedge(); check("tp_grant2", 32'(req_ready), 32'h4);
    check("tp_rsp1", 32'(rsp_valid), 32'h4);
    pedge(); req_valid = '0;
    nedge(); check("tp_rsp2", 32'(rsp_valid), 32'h4);
    check("tp_idle", 32'(req_ready), 32'h0);
    pedge();

    // 3: backpressure on requester 1 for three cycles
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    nedge();
    check("bp_grant1", 32'(req_ready), 32'h2);
    check("bp_en_pre", 32'(dp_enable), 32'h1);
    pedge();
    req_valid = 4'b1101;
    held_mant = '0;
    for (int c = 0; c < 3; c++) begin
      nedge();
      if (c == 0) held_mant = rsp_mant;
      check("bp_enable", 32'(dp_enable), 32'h0);
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_rsp", 32'(rsp_valid), 32'h2);
      check("bp_mant", 32'(rsp_mant), 32'(held_mant));
      pedge();
    end
    rsp_ready = 4'hF;
    nedge();
    check("bp_release_en", 32'(dp_enable), 32'h1);
    check("bp_release_rsp", 32'(rsp_valid), 32'h2);
    check("bp_next_grant", 32'(req_ready), 32'h4);
    pedge();
    req_valid = '0;
    nedge();
    check("bp_rsp_next", 32'(rsp_valid), 32'h4);
    pedge();

    // 4: clear while requester 3 is in flight
    req_valid = 4'b1000;
    nedge(); check("clr_grant3", 32'(req_ready), 32'h8);
    pedge();
    req_valid = '0; rsp_ready = '0; clear = 1'b1;
    nedge();
    check("clr_dp_clear", 32'(dp_clear), 32'h1);
    check("clr_rsp_tail", 32'(rsp_valid), 32'h8);
    check("clr_no_grant", 32'(req_ready), 32'h0);
    pedge();
    clear = 1'b0; rsp_ready = 4'hF; req_valid = 4'hF;
    nedge();
    check("clr_dp_clear_off", 32'(dp_clear), 32'h0);
    check("clr_rsp_gone", 32'(rsp_valid), 32'h0);
    check("clr_grant0", 32'(req_ready), 32'h1);
    pedge();
    req_valid = '0;
    nedge(); check("clr_rsp0", 32'(rsp_valid), 32'h1);
    pedge();

    // 5: reset with a result in flight
    req_valid = 4'hF;
    nedge(); check("rst_pre_grant", 32'(req_ready), 32'h2);
    pedge();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      nedge(); check("rst_mid_rsp", 32'(rsp_valid), 32'h0);
      pedge();
    end
    rst_n = 1'b1;
    nedge();
    check("rst_post_rsp", 32'(rsp_valid), 32'h0);
    check("rst_post_grant", 32'(req_ready), 32'h1);
    pedge();
    req_valid = '0;
    nedge(); check("rst_post_rsp0", 32'(rsp_valid), 32'h1);
    pedge();

    // 6: wrap-around fairness from last = 3
    req_valid = 4'b1000;
    nedge(); check("wrap_seed", 32'(req_ready), 32'h8);
    pedge();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      nedge();
      check("wrap_grant", 32'(req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
      pedge();
    end
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      nedge();
      pedge();
    end
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
